yannickreiss_diamond_route_ctrl: RTL
====================================

# yannickreiss_diamond_route_ctrl

Sequential route controller for the switch diamond (four entries NW, SW, NE, SE; north track NW–NE, south track SW–SE; crossover joins NW–SE and SW–NE). The controller arbitrates train requests round-robin and commands the crossover switch with a settle delay. It clears entry signals, then holds the route until the diamond occupancy detector shows the train has passed. It sits between the track-side request/occupancy sensors and the combinational signal/switch drivers.

## Interface
- `SETTLE_CYCLES`, default 16: switch motor settle time in cycles. Must be ≥1.
- `ENTER_TIMEOUT`, default 200: cycles a cleared signal waits for the train to enter. Must be ≥1.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `req`  in  4  per-entry route request, bit order [0]=NW, [1]=SW, [2]=NE, [3]=SE. Level, held by the requester.
- `xover`  in  4  per-entry desired route: 1 = crossover, 0 = straight. Sampled with `req`.
- `occ`  in  1  diamond occupancy detector, asynchronous.
- `sig`  out  4  per-entry proceed signal. Same bit order as `req`.
- `switch_cmd`  out  1  switch position command: 1 = crossover, 0 = straight.
- `busy`  out  1  high in every state except IDLE.
- `fault`  out  1  high while IDLE and the synchronized `occ` is high.
- `done`  out  1  one-cycle pulse in RELEASE.

## Operation
- `occ` passes through a 2-FF synchronizer. `occ_s` is the synchronized value; all logic uses `occ_s`.
- States: IDLE, THROW, PROCEED, OCCUPIED, RELEASE.
- **IDLE**
  - If `occ_s` is high: `fault`=1 and no grant is made.
  - Otherwise, if any `req` is set: pick the winner W, the first requesting entry at or after `rr_ptr`, scanning modulo 4.
  - Grant mask = {W}.
  - If `xover[W]`=0, also grant the first straight requester on the other track. For W on north, scan SW then SE; for W on south, scan NW then NE. That requester must have `xover`=0.
  - Latch the mask and the route bit R=`xover[W]`.
  - If R ≠ `switch_cmd`: set `switch_cmd`←R, load the counter with SETTLE_CYCLES−1, go to THROW. Otherwise go to PROCEED.
- **THROW**: `sig`=0. Decrement the counter; when it reaches 0, go to PROCEED.
- **PROCEED**
  - `sig` = grant mask. The counter is loaded with ENTER_TIMEOUT−1 on entry.
  - `occ_s` rising → OCCUPIED.
  - Else if all granted `req` bits have dropped → RELEASE.
  - Else on counter 0 → RELEASE (timeout).
  - Priority: `occ_s` > withdrawal > timeout.
- **OCCUPIED**: `sig`=0. Wait for `occ_s` low on 2 consecutive cycles, then go to RELEASE.
- **RELEASE**: `sig`=0, `done`=1, `rr_ptr` ← W+1 (mod 4), go to IDLE.
- `switch_cmd` holds its last position across routes. It is never returned to straight automatically.
- Two concurrent straight grants share the single `occ`. OCCUPIED ends only when both trains have cleared.

## Timing
- Reset values: state=IDLE, `rr_ptr`=0, `switch_cmd`=0, `sig`=0, `busy`=0, `fault`=0, `done`=0, counter=0, synchronizer=0.
- Reset asserted mid-route returns all outputs to their reset values asynchronously. This includes `switch_cmd` going to 0, which is an intentional throw to straight.
- `req`/`xover` are sampled in IDLE only. Changes to `xover` after the grant are ignored.
- Latency, `req` to `sig` with no throw needed: `req` high at edge n → PROCEED at edge n+1 → `sig` visible after edge n+1.
- With a throw: `sig` is first high SETTLE_CYCLES+1 cycles after the IDLE decision edge.
- `occ` pin to state change: 2 cycles of synchronizer latency, plus 1 cycle.
- Timeout: PROCEED lasts exactly ENTER_TIMEOUT cycles if `occ_s` never rises and the request is held.
- `sig` and `switch_cmd` never change in the same cycle. `switch_cmd` changes only on the IDLE→THROW edge.
- Counter width: `$clog2(max(SETTLE_CYCLES, ENTER_TIMEOUT))`, minimum 1. No wrap-around; the counter is reloaded on every entry to THROW/PROCEED.

## Structure
- Package `yannickreiss_diamond_pkg`:
  - state encoding (5 states, 3 bits);
  - entry indices NW=0, SW=1, NE=2, SE=3;
  - track membership constants (north {0,2}, south {1,3}).
- Sub-module `yannickreiss_rr_pick4`: combinational 4-way round-robin picker. Inputs: 4-bit request, 2-bit pointer. Outputs: one-hot grant, 2-bit index, valid.
- All other logic (synchronizer, FSM, counter, output registers) lives in the top module. All outputs are registered.

## Test plan
- Reset, then `req`=0001, `xover`=0000 → no throw. `sig`=0001 one cycle after the decision edge; `switch_cmd` stays 0. Pulse `occ`: `sig`=0 in OCCUPIED, then `done` pulses and `rr_ptr`=1.
- `req`=0011, `xover`=0000 → grant mask 0011 (NW + SW concurrently). `occ` held high 10 cycles then low → RELEASE 2 cycles after `occ_s` falls.
- `req`=0001, `xover`=0001, SETTLE_CYCLES=16 → `switch_cmd`=1 at the decision edge. `sig`=0001 exactly 17 cycles later. A following crossover route causes no throw.
- All four `req` held continuously, with a full `occ` pulse per route → winners in the order NW, SW, NE, SE, NW.
- Timeout: `req`=0100 held, `occ`=0 → `sig` high for exactly ENTER_TIMEOUT cycles, then `done`. Separately, `occ` rising on the timeout cycle → OCCUPIED wins.
- `occ` high at IDLE with `req`=1111 → `fault`=1, no `sig`. Also: `rst_n` low during THROW → `switch_cmd`=0, `sig`=0, `busy`=0 immediately, without waiting for `clk`.

Source files
------------

// File: rtl/yannickreiss_diamond_pkg.sv
// Shared constants for the diamond route controller: FSM encoding, entry indices, track membership.
// Also holds the straight-partner selection used when a straight route lets a second train in.
package yannickreiss_diamond_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_THROW    = 3'd1;
  localparam logic [2:0] ST_PROCEED  = 3'd2;
  localparam logic [2:0] ST_OCCUPIED = 3'd3;
  localparam logic [2:0] ST_RELEASE  = 3'd4;

  localparam logic [1:0] NW = 2'd0;
  localparam logic [1:0] SW = 2'd1;
  localparam logic [1:0] NE = 2'd2;
  localparam logic [1:0] SE = 2'd3;

  localparam logic [3:0] NORTH_TRACK = 4'b0101;
  localparam logic [3:0] SOUTH_TRACK = 4'b1010;

  // First straight requester on the track opposite the winner; scan order is ascending entry index.
  function automatic logic [3:0] straight_partner(input logic [1:0] win,
                                                  input logic [3:0] req,
                                                  input logic [3:0] xover);
    logic [3:0] other;
    logic [3:0] cand;
    straight_partner = 4'b0000;
    other = NORTH_TRACK[win] ? SOUTH_TRACK : NORTH_TRACK;
    cand  = req & ~xover & other;
    for (int i = 0; i < 4; i++) begin
      if (cand[i] && (straight_partner == 4'b0000)) straight_partner[i] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/yannickreiss_rr_pick4.sv
// Combinational 4-way round-robin picker: first request at or after ptr, modulo 4.
// Zero latency; no flow control.
module yannickreiss_rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] idx,
  output logic       vld
);

  logic [1:0] k;

  always_comb begin
    gnt = 4'b0000;
    idx = 2'd0;
    vld = 1'b0;
    k   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      k = ptr + 2'(i);
      if (!vld && req[k]) begin
        vld    = 1'b1;
        idx    = k;
        gnt[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/yannickreiss_diamond_route_ctrl.sv
// Diamond route controller: round-robin grant, crossover throw with settle delay, hold until the train clears.
// Outputs are registered decodes of the previous state; requests are level-held, so there is no backpressure.
module yannickreiss_diamond_route_ctrl
  import yannickreiss_diamond_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int ENTER_TIMEOUT = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] xover,
  input  logic       occ,
  output logic [3:0] sig,
  output logic       switch_cmd,
  output logic       busy,
  output logic       fault,
  output logic       done
);

  localparam int CNT_MAX = (SETTLE_CYCLES > ENTER_TIMEOUT) ? SETTLE_CYCLES : ENTER_TIMEOUT;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] ENTER_LOAD  = CW'(ENTER_TIMEOUT - 1);

  logic          occ_m, occ_s, occ_s_q;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    rr_ptr;
  logic [1:0]    win;
  logic [3:0]    grant;

  logic [3:0]    pick_gnt;
  logic [1:0]    pick_idx;
  logic          pick_vld;
  logic          occ_rise;

  yannickreiss_rr_pick4 u_pick (
    .req (req),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  assign occ_rise = occ_s & ~occ_s_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_m      <= 1'b0;
      occ_s      <= 1'b0;
      occ_s_q    <= 1'b0;
      state      <= ST_IDLE;
      cnt        <= '0;
      rr_ptr     <= 2'd0;
      win        <= 2'd0;
      grant      <= 4'b0000;
      sig        <= 4'b0000;
      switch_cmd <= 1'b0;
      busy       <= 1'b0;
      fault      <= 1'b0;
      done       <= 1'b0;
    end else begin
      occ_m   <= occ;
      occ_s   <= occ_m;
      occ_s_q <= occ_s;

      sig   <= (state == ST_PROCEED) ? grant : 4'b0000;
      busy  <= (state != ST_IDLE);
      fault <= (state == ST_IDLE) && occ_s;
      done  <= (state == ST_RELEASE);

      case (state)
        ST_IDLE: begin
          if (!occ_s && pick_vld) begin
            grant <= pick_gnt | (xover[pick_idx] ? 4'b0000
                                                 : straight_partner(pick_idx, req, xover));
            win   <= pick_idx;
            // The motor is only driven when the requested route differs from where it already sits.
            if (xover[pick_idx] != switch_cmd) begin
              switch_cmd <= xover[pick_idx];
              cnt        <= SETTLE_LOAD;
              state      <= ST_THROW;
            end else begin
              cnt   <= ENTER_LOAD;
              state <= ST_PROCEED;
            end
          end
        end
        ST_THROW: begin
          if (cnt == '0) begin
            cnt   <= ENTER_LOAD;
            state <= ST_PROCEED;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_PROCEED: begin
          if (occ_rise) begin
            state <= ST_OCCUPIED;
          end else if ((req & grant) == 4'b0000) begin
            state <= ST_RELEASE;
          end else if (cnt == '0) begin
            state <= ST_RELEASE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_OCCUPIED: begin
          // Both trains of a dual straight grant share occ, so wait for a clean two-cycle low.
          if (!occ_s && !occ_s_q) state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          rr_ptr <= win + 2'd1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
